// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller signal bundle: request pulses, live counter digits,
// counter control strobes, display drive and debug state.
interface stopwatch_ctrl_if;
  logic       start_stop;
  logic       lap_clr;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic       cnt_en;
  logic       cnt_clr;
  logic [3:0] disp_bcd;
  logic [3:0] an;
  logic [1:0] state;

  // Environment side: issues requests, supplies digits, observes outputs.
  modport master (
    output start_stop, lap_clr, d0, d1, d2, d3,
    input  cnt_en, cnt_clr, disp_bcd, an, state
  );

  // Controller side.
  modport slave (
    input  start_stop, lap_clr, d0, d1, d2, d3,
    output cnt_en, cnt_clr, disp_bcd, an, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap/clear FSM, count-tick prescaler with
// 9999 saturation, lap snapshot and multiplexed seven-segment scan with
// optional leading-zero blanking.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  state_t              cur;
  state_t              nxt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [1:0]          idx;
  logic [15:0]         live;
  logic [15:0]         snap;
  logic [15:0]         src;
  logic [3:0]          blank;
  logic                running;
  logic                tick;
  logic                at_max;
  logic                take_snap;
  logic                clr_req;
  logic                cnt_en_c;
  logic                cnt_clr_q;
  logic [3:0]          disp_c;
  logic [3:0]          an_c;

  assign live    = {bus.d3, bus.d2, bus.d1, bus.d0};
  assign running = (cur == RUN) || (cur == LAP);
  assign at_max  = (live == 16'h9999);
  assign tick    = running && (tick_cnt == TICK_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // Next-state and request decode; a tick at 9999 forces PAUSE and
  // suppresses the enable so the counter chain holds at its maximum.
  always_comb begin
    nxt       = cur;
    take_snap = 1'b0;
    clr_req   = 1'b0;
    cnt_en_c  = 1'b0;
    if (tick && at_max) begin
      nxt = PAUSE;
    end else begin
      cnt_en_c = tick;
      case (cur)
        IDLE: begin
          if (bus.start_stop) begin
            nxt = RUN;
          end else if (bus.lap_clr) begin
            clr_req = 1'b1;
          end
        end
        RUN: begin
          if (bus.start_stop) begin
            nxt = PAUSE;
          end else if (bus.lap_clr) begin
            nxt       = LAP;
            take_snap = 1'b1;
          end
        end
        LAP: begin
          if (bus.start_stop) begin
            nxt = PAUSE;
          end else if (bus.lap_clr) begin
            nxt = RUN;
          end
        end
        PAUSE: begin
          if (bus.start_stop) begin
            nxt = RUN;
          end else if (bus.lap_clr) begin
            nxt     = IDLE;
            clr_req = 1'b1;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Tick prescaler: counts only while running, so pausing drops the partial tick.
  always_ff @(posedge clk) begin
    if (rst || !running) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Free-running scan prescaler and digit slot index.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Lap snapshot of the live digits, taken on the RUN -> LAP edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
    end else if (take_snap) begin
      snap <= live;
    end
  end

  // Registered clear strobe, high for the cycle after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_clr_q <= 1'b0;
    end else begin
      cnt_clr_q <= clr_req;
    end
  end

  assign src = (cur == LAP) ? snap : live;

  // Leading-zero mask: a slot blanks when it and every higher digit are zero.
  always_comb begin
    blank    = '0;
    blank[3] = (BLANK_LZ != 0) && (src[15:12] == 4'd0);
    blank[2] = blank[3] && (src[11:8] == 4'd0);
    blank[1] = blank[2] && (src[7:4] == 4'd0);
  end

  // Digit mux and active-low one-hot anode drive for the current slot.
  always_comb begin
    disp_c = '0;
    case (idx)
      2'd0:    disp_c = src[3:0];
      2'd1:    disp_c = src[7:4];
      2'd2:    disp_c = src[11:8];
      default: disp_c = src[15:12];
    endcase
    if (blank[idx]) begin
      an_c = '1;
    end else begin
      an_c = ~(4'b0001 << idx);
    end
  end

  assign bus.cnt_en   = cnt_en_c;
  assign bus.cnt_clr  = cnt_clr_q;
  assign bus.disp_bcd = disp_c;
  assign bus.an       = an_c;
  assign bus.state    = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed vector table, corner sequences and a
// randomized run against a cycle-level behavioural model.
module tb_stopwatch_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned SD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  stopwatch_ctrl_if bus();

  stopwatch_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD), .BLANK_LZ(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model. Modes use the published encoding:
  // 0 idle, 1 run, 2 pause, 3 lap.
  int          m_mode  = 0;
  int          m_run   = 0;   // cycles spent running since last stop
  int          m_cyc   = 0;   // cycles since last reset
  logic [15:0] m_snap  = '0;
  logic        m_clr   = 1'b0;
  bit          m_valid = 1'b0;
  // next mode indexed by [mode][request]; request 0 none, 1 start_stop, 2 lap_clr
  int next_mode [4][3] = '{'{0, 1, 0}, '{1, 2, 3}, '{2, 1, 0}, '{3, 2, 1}};

  logic [15:0] dig      = '0;
  int          cnt_val  = 0;
  bit          auto_cnt = 1'b0;

  logic        e_en;
  logic        e_sat;
  logic [3:0]  e_an;
  logic [3:0]  e_bcd;

  typedef struct {
    bit          chk;
    bit          r;
    bit          ss;
    bit          lc;
    logic [15:0] dg;
    logic [1:0]  st;
    bit          en;
    bit          clr;
    logic [3:0]  an;
    logic [3:0]  bcd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit chk, bit r, bit ss, bit lc, logic [15:0] dg,
                              logic [1:0] st, bit en, bit clr, logic [3:0] an,
                              logic [3:0] bcd);
    vec_t v;
    v.chk = chk; v.r = r; v.ss = ss; v.lc = lc; v.dg = dg;
    v.st = st; v.en = en; v.clr = clr; v.an = an; v.bcd = bcd;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] b;
    b[15:12] = 4'((v / 1000) % 10);
    b[11:8]  = 4'((v / 100) % 10);
    b[7:4]   = 4'((v / 10) % 10);
    b[3:0]   = 4'(v % 10);
    return b;
  endfunction

  function automatic logic [15:0] dut_bundle();
    return {2'b00, bus.state, bus.cnt_en, bus.cnt_clr, bus.an, bus.disp_bcd};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function void model_eval();
    int          idx;
    int          hi;
    bit          tck;
    logic [15:0] s;
    tck   = ((m_mode == 1) || (m_mode == 3)) && ((m_run % TD) == TD - 1);
    e_sat = tck && (dig == 16'h9999);
    e_en  = tck && !e_sat;
    idx   = (m_cyc / SD) % 4;
    s     = (m_mode == 3) ? m_snap : dig;
    hi    = 0;
    for (int k = 1; k < 4; k++) begin
      if (s[4*k +: 4] != 4'd0) hi = k;
    end
    e_bcd = s[4*idx +: 4];
    e_an  = (idx > hi) ? 4'hF : ~(4'b0001 << idx);
  endfunction

  // Apply inputs for one cycle and compare the settled outputs with the model.
  task automatic drive(input bit r, input bit ss, input bit lc);
    rst            = r;
    bus.start_stop = ss;
    bus.lap_clr    = lc;
    {bus.d3, bus.d2, bus.d1, bus.d0} = dig;
    #1;
    model_eval();
    if (m_valid) begin
      check($sformatf("model c%0d", m_cyc), dut_bundle(),
            {2'b00, 2'(m_mode), e_en, m_clr, e_an, e_bcd});
    end
  endtask

  // Cross the clock edge and step the model and the external counter chain.
  task automatic advance(input bit r, input bit ss, input bit lc);
    int   req;
    bit   was_run;
    logic old_clr;
    logic old_en;
    @(posedge clk);
    old_clr = m_clr;
    old_en  = e_en;
    if (r) begin
      m_mode  = 0;
      m_run   = 0;
      m_cyc   = 0;
      m_snap  = '0;
      m_clr   = 1'b0;
      m_valid = 1'b1;
    end else begin
      req     = ss ? 1 : (lc ? 2 : 0);
      was_run = (m_mode == 1) || (m_mode == 3);
      m_clr   = !e_sat && (req == 2) && ((m_mode == 0) || (m_mode == 2));
      if (!e_sat && (req == 2) && (m_mode == 1)) m_snap = dig;
      m_mode  = e_sat ? 2 : next_mode[m_mode][req];
      m_run   = was_run ? m_run + 1 : 0;
      m_cyc++;
    end
    if (auto_cnt) begin
      if (old_clr) cnt_val = 0;
      else if (old_en) cnt_val++;
      dig = to_bcd(cnt_val);
    end
    @(negedge clk);
  endtask

  initial begin
    // chk, rst, ss, lc, digits, state, cnt_en, cnt_clr, an, disp_bcd
    tbl.push_back(mk(0, 1, 0, 0, 16'h0042, 2'd0, 0, 0, 4'hE, 4'd2));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0042, 2'd0, 0, 0, 4'hE, 4'd2));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0042, 2'd1, 0, 0, 4'hE, 4'd2));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0042, 2'd1, 0, 0, 4'hD, 4'd4));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0042, 2'd1, 0, 0, 4'hD, 4'd4));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0042, 2'd1, 1, 0, 4'hF, 4'd0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0042, 2'd1, 0, 0, 4'hF, 4'd0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0042, 2'd1, 0, 0, 4'hF, 4'd0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0042, 2'd1, 0, 0, 4'hF, 4'd0));
    tbl.push_back(mk(1, 0, 0, 1, 16'h0042, 2'd1, 1, 0, 4'hE, 4'd2));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0045, 2'd3, 0, 0, 4'hE, 4'd2));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0045, 2'd3, 0, 0, 4'hD, 4'd4));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0045, 2'd3, 0, 0, 4'hD, 4'd4));
    tbl.push_back(mk(1, 0, 0, 1, 16'h0045, 2'd3, 1, 0, 4'hF, 4'd0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0045, 2'd1, 0, 0, 4'hF, 4'd0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0045, 2'd1, 0, 0, 4'hF, 4'd0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0045, 2'd1, 0, 0, 4'hF, 4'd0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0045, 2'd1, 1, 0, 4'hE, 4'd5));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0045, 2'd1, 0, 0, 4'hE, 4'd5));
    tbl.push_back(mk(1, 0, 0, 1, 16'h0045, 2'd2, 0, 0, 4'hD, 4'd4));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0045, 2'd0, 0, 1, 4'hD, 4'd4));
    tbl.push_back(mk(1, 0, 1, 0, 16'h0045, 2'd0, 0, 0, 4'hF, 4'd0));
    tbl.push_back(mk(1, 0, 1, 1, 16'h0045, 2'd1, 0, 0, 4'hF, 4'd0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0045, 2'd2, 0, 0, 4'hF, 4'd0));
    tbl.push_back(mk(1, 0, 0, 0, 16'h0045, 2'd2, 0, 0, 4'hF, 4'd0));

    foreach (tbl[i]) begin
      dig = tbl[i].dg;
      drive(tbl[i].r, tbl[i].ss, tbl[i].lc);
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d", i), dut_bundle(),
              {2'b00, tbl[i].st, tbl[i].en, tbl[i].clr, tbl[i].an, tbl[i].bcd});
      end
      advance(tbl[i].r, tbl[i].ss, tbl[i].lc);
    end

    // Saturation: digits held at 9999 when the tick comes due.
    dig = 16'h9999;
    drive(0, 1, 0); advance(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0); advance(0, 0, 0);
    end
    drive(0, 0, 0);
    check("sat_en", {15'd0, bus.cnt_en}, 16'h0000);
    advance(0, 0, 0);
    drive(0, 0, 0);
    check("sat_state", {14'd0, bus.state}, 16'h0002);
    advance(0, 0, 0);

    // Reset asserted for one edge while in LAP.
    dig = 16'h0123;
    drive(0, 1, 0); advance(0, 1, 0);
    drive(0, 0, 1); advance(0, 0, 1);
    dig = 16'h0456;
    drive(0, 0, 0);
    check("lap_hold", {12'd0, bus.disp_bcd}, 16'h0003);
    advance(0, 0, 0);
    drive(1, 0, 0); advance(1, 0, 0);
    drive(0, 0, 0);
    check("rst_state", {14'd0, bus.state}, 16'h0000);
    check("rst_an", {12'd0, bus.an}, 16'h000E);
    check("rst_en", {15'd0, bus.cnt_en}, 16'h0000);
    check("rst_bcd", {12'd0, bus.disp_bcd}, 16'h0006);
    advance(0, 0, 0);

    // Randomized run with the counter chain following the enable/clear strobes.
    auto_cnt = 1'b1;
    cnt_val  = 0;
    dig      = to_bcd(cnt_val);
    for (int i = 0; i < 1500; i++) begin
      bit r;
      bit ss;
      bit lc;
      r  = ($urandom_range(0, 99) == 0);
      ss = ($urandom_range(0, 9) == 0);
      lc = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 119) == 0) begin
        cnt_val = ($urandom_range(0, 1) == 0) ? 9996 : int'($urandom_range(0, 9999));
        dig     = to_bcd(cnt_val);
      end
      drive(r, ss, lc);
      advance(r, ss, lc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
